// File: rtl/upcounter_sequencer_pkg.sv
// Shared constants and types for the up-counter sequencer and its counter instance.
package upcounter_sequencer_pkg;

  // Counter width shared by the sequencer and the counter it drives.
  localparam int unsigned CntW   = 4;
  localparam int unsigned StateW = 3;

  // Encodings are visible on the state output, so they are fixed explicitly.
  typedef enum logic [StateW-1:0] {
    StIdle  = 3'd0,
    StClear = 3'd1,
    StRun   = 3'd2,
    StPause = 3'd3,
    StDone  = 3'd4
  } state_e;

  function automatic logic is_busy(state_e s);
    return (s == StClear) || (s == StRun) || (s == StPause);
  endfunction

endpackage

// File: rtl/upcounter_sequencer_tick_prescaler.sv
// Free-running divider: emits one tick every DIV enabled clocks, holds while disabled.
module tick_prescaler #(
  parameter int unsigned DIV = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] Last = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == Last);

  // Next count: clear wins, otherwise wrap at DIV-1 while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == Last) ? '0 : cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/upcounter_sequencer.sv
// Sequencer for the W-bit up-counter: clear, paced up-enable, terminal detect,
// pause/resume and optional auto-reload.
module upcounter_sequencer
  import upcounter_sequencer_pkg::*;
#(
  parameter int unsigned W   = CntW,
  parameter int unsigned DIV = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              clr,
  input  logic              mode_auto,
  input  logic [W-1:0]      term,
  input  logic [W-1:0]      cnt_q,
  output logic              cnt_up,
  output logic              cnt_clr,
  output logic              done,
  output logic              busy,
  output logic [StateW-1:0] state
);

  state_e state_q, state_d;
  logic   cnt_clr_q, done_q, busy_q;
  logic   at_term, tick, presc_clr, presc_en;

  assign at_term   = (cnt_q == term);
  assign presc_clr = (state_q == StClear);
  assign presc_en  = (state_q == StRun);

  tick_prescaler #(
    .DIV(DIV)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .clr (presc_clr),
    .en  (presc_en),
    .tick(tick)
  );

  // Gating by the compare keeps the counter from ever stepping past term.
  assign cnt_up = tick && !at_term;

  // Next state: clr beats everything, stop beats start, terminal beats stop.
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = StClear;
    end else begin
      case (state_q)
        StIdle:  if (!stop && start) state_d = StClear;
        StClear: state_d = StRun;
        StRun: begin
          if (at_term)   state_d = StDone;
          else if (stop) state_d = StPause;
        end
        StPause: if (!stop && start) state_d = StRun;
        StDone:  if (mode_auto || (!stop && start)) state_d = StClear;
        default: state_d = StIdle;
      endcase
    end
  end

  // State and registered outputs; cnt_clr is held high through reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_clr_q <= 1'b1;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_clr_q <= (state_d == StClear);
      done_q    <= (state_q == StRun) && (state_d == StDone);
      busy_q    <= is_busy(state_d);
    end
  end

  assign cnt_clr = cnt_clr_q;
  assign done    = done_q;
  assign busy    = busy_q;
  assign state   = state_q;

endmodule

// File: tb/tb_upcounter_sequencer.sv
// Bench: two sequencers (DIV=3 and DIV=1) share controls, each drives its own counter.
module tb_upcounter_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, start = 1'b0, stop = 1'b0, clr = 1'b0, mode_auto = 1'b0;
  logic [3:0] term = 4'd5;

  logic       up0, cc0, done0, busy0, up1, cc1, done1, busy1;
  logic [2:0] st0, st1;
  logic [3:0] q0 = 4'd0, q1 = 4'd0;

  upcounter_sequencer #(.W(4), .DIV(3)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clr(clr), .mode_auto(mode_auto),
    .term(term), .cnt_q(q0), .cnt_up(up0), .cnt_clr(cc0), .done(done0), .busy(busy0),
    .state(st0)
  );

  upcounter_sequencer #(.W(4), .DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clr(clr), .mode_auto(mode_auto),
    .term(term), .cnt_q(q1), .cnt_up(up1), .cnt_clr(cc1), .done(done1), .busy(busy1),
    .state(st1)
  );

  // Counters under control, with active-high asynchronous clear.
  always @(posedge clk or posedge cc0) begin
    if (cc0) q0 <= 4'd0;
    else if (up0) q0 <= q0 + 4'd1;
  end
  always @(posedge clk or posedge cc1) begin
    if (cc1) q1 <= 4'd0;
    else if (up1) q1 <= q1 + 4'd1;
  end

  int n_pass = 0, n_tot = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference model: 0 idle, 1 clear, 2 run, 3 pause, 4 done.
  int m_s[2], m_p[2], m_c[2];
  bit m_tail[2], m_done[2];

  function automatic int div_of(input int k);
    return (k == 0) ? 3 : 1;
  endfunction

  function automatic bit exp_up(input int s, input int p, input int c, input int d);
    return (s == 2) && (p == d - 1) && (c != int'(term));
  endfunction

  function automatic void step(input int s, input int p, input int c, input int d,
                               output int ns, output int np, output int nc, output bit dn);
    bit up;
    up = exp_up(s, p, c, d);
    ns = s;
    if (clr) ns = 1;
    else if (s == 0) ns = (start && !stop) ? 1 : 0;
    else if (s == 1) ns = 2;
    else if (s == 2) ns = (c == int'(term)) ? 4 : (stop ? 3 : 2);
    else if (s == 3) ns = (start && !stop) ? 2 : 3;
    else if (s == 4) ns = (mode_auto || (start && !stop)) ? 1 : 4;
    np = (s == 1) ? 0 : ((s == 2) ? (p + 1) % d : p);
    nc = (ns == 1) ? 0 : (up ? (c + 1) % 16 : c);
    dn = (s == 2) && (ns == 4);
  endfunction

  always @(posedge clk or negedge rst) begin
    int ns, np, nc;
    bit dn;
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        m_s[k] <= 0; m_p[k] <= 0; m_c[k] <= 0; m_tail[k] <= 1'b1; m_done[k] <= 1'b0;
      end else begin
        step(m_s[k], m_p[k], m_c[k], div_of(k), ns, np, nc, dn);
        m_s[k] <= ns; m_p[k] <= np; m_c[k] <= nc; m_done[k] <= dn; m_tail[k] <= 1'b0;
      end
    end
  end

  task automatic check_dut(input int k, input logic [2:0] st, input logic up, input logic cc,
                           input logic dn, input logic bs, input logic [3:0] q);
    chk($sformatf("dut%0d_state", k), int'(st), m_s[k]);
    chk($sformatf("dut%0d_cnt_up", k), int'(up), int'(exp_up(m_s[k], m_p[k], m_c[k], div_of(k))));
    chk($sformatf("dut%0d_cnt_clr", k), int'(cc), int'((m_s[k] == 1) || m_tail[k]));
    chk($sformatf("dut%0d_done", k), int'(dn), int'(m_done[k]));
    chk($sformatf("dut%0d_busy", k), int'(bs), int'(m_s[k] >= 1 && m_s[k] <= 3));
    chk($sformatf("dut%0d_cnt_q", k), int'(q), m_c[k]);
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check_dut(0, st0, up0, cc0, done0, busy0, q0);
    check_dut(1, st1, up1, cc1, done1, busy1, q1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  int n, ups, ups1, dn, first, second;

  initial begin
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", int'(st0), 0);
    chk("rst_cnt_clr", int'(cc0), 1);
    chk("rst_cnt_up", int'(up0), 0);
    chk("rst_busy", int'(busy0), 0);
    rst = 1'b1;
    repeat (3) tick();
    chk("idle_after_rst_state", int'(st0), 0);
    chk("idle_after_rst_cnt_clr", int'(cc0), 0);

    // One-shot, DIV=3, term=5.
    term = 4'd5; mode_auto = 1'b0; start = 1'b1;
    n = 0; ups = 0; dn = 0;
    do begin
      tick(); start = 1'b0; n++; ups += int'(up0); dn += int'(done0);
    end while (st0 != 3'd4 && n < 100);
    chk("oneshot_cycles_to_done", n, 18);
    chk("oneshot_up_pulses", ups, 5);
    repeat (5) begin tick(); dn += int'(done0); end
    chk("oneshot_done_pulses", dn, 1);
    chk("oneshot_hold_state", int'(st0), 4);
    chk("oneshot_hold_q", int'(q0), 5);

    // Pause/resume.
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (q0 != 4'd2 && n < 100) begin tick(); n++; end
    chk("pause_reach_q2", int'(q0), 2);
    stop = 1'b1; ups = 0;
    repeat (6) begin tick(); ups += int'(up0); end
    stop = 1'b0;
    chk("pause_no_up", ups, 0);
    chk("pause_hold_q", int'(q0), 2);
    chk("pause_state", int'(st0), 3);
    start = 1'b1; tick(); start = 1'b0;
    n = 1;
    while (!up0 && n < 20) begin tick(); n++; end
    chk("resume_latency", n, 2);
    while (st0 != 3'd4 && n < 100) begin tick(); n++; end
    chk("pause_final_q", int'(q0), 5);

    // Auto-reload, DIV=1, term=3.
    term = 4'd3; mode_auto = 1'b1;
    pulse_clr();
    n = 0; first = -1; second = -1;
    while (second < 0 && n < 100) begin
      tick(); n++;
      if (done1) begin
        if (first < 0) first = n;
        else second = n;
      end
    end
    chk("auto_done_period", second - first, 6);
    mode_auto = 1'b0;

    // term = 0: no up pulses at all.
    term = 4'd0;
    pulse_clr();
    n = 1; ups = 0; ups1 = 0;
    while ((st0 != 3'd4 || st1 != 3'd4) && n < 50) begin
      tick(); n++; ups += int'(up0); ups1 += int'(up1);
    end
    chk("term0_cycles", n, 3);
    chk("term0_ups_div3", ups, 0);
    chk("term0_ups_div1", ups1, 0);

    // Full scale, DIV=1: no wrap.
    term = 4'd15;
    pulse_clr();
    n = 1;
    while (st1 != 3'd4 && n < 60) begin tick(); n++; end
    chk("full_cycles", n, 18);
    repeat (4) tick();
    chk("full_q_no_wrap", int'(q1), 15);

    // clr+stop+start together in RUN.
    pulse_clr();
    n = 0;
    while (q0 != 4'd2 && n < 100) begin tick(); n++; end
    clr = 1'b1; stop = 1'b1; start = 1'b1;
    tick();
    clr = 1'b0; stop = 1'b0; start = 1'b0;
    chk("prio_state_clear", int'(st0), 1);
    chk("prio_cnt_clr", int'(cc0), 1);
    tick();
    chk("prio_q_zero", int'(q0), 0);
    chk("prio_state_run", int'(st0), 2);

    // Stop coincident with terminal count.
    term = 4'd3;
    pulse_clr();
    n = 0;
    while (!(q1 == 4'd3 && st1 == 3'd2) && n < 30) begin tick(); n++; end
    stop = 1'b1; tick(); stop = 1'b0;
    chk("coincide_state_done", int'(st1), 4);
    chk("coincide_done", int'(done1), 1);

    // Asynchronous reset mid-RUN.
    term = 4'd9;
    pulse_clr();
    n = 0;
    while (q0 != 4'd1 && n < 100) begin tick(); n++; end
    #2 rst = 1'b0;
    #1;
    chk("async_rst_cnt_clr", int'(cc0), 1);
    chk("async_rst_cnt_up", int'(up0), 0);
    chk("async_rst_state", int'(st0), 0);
    chk("async_rst_busy", int'(busy0), 0);
    chk("async_rst_done", int'(done0), 0);
    chk("async_rst_state_div1", int'(st1), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) tick();
    chk("after_async_rst_idle", int'(st0), 0);

    // Randomised controls, checked cycle by cycle against the model.
    repeat (3000) begin
      tick();
      start = ($urandom % 4) == 0;
      stop  = ($urandom % 6) == 0;
      clr   = ($urandom % 20) == 0;
      if (($urandom % 50) == 0) mode_auto = ~mode_auto;
      if (($urandom % 40) == 0) term = 4'($urandom % 16);
      if (($urandom % 400) == 0) begin
        #1 rst = 1'b0;
        #1 rst = 1'b1;
      end
    end

    tick();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
